sha2_msg_schedule: RTL

Streaming SHA-2 message-schedule generator, parametrised for SHA-224/256 (32-bit words, 64 rounds) and SHA-384/512 (64-bit words, 80 rounds). Accepts one 16-word message block over a valid/ready input, then emits W[0..ROUNDS-1] one word per cycle over a valid/ready output. It sits between the block padder and the compression round engine, replacing the combinational sigma helpers with a buffered, back-pressurable schedule.

---
 rtl/sha2_msg_schedule_pkg.sv | 43 ++++
 rtl/sha2_msg_schedule_if.sv | 36 +++
 rtl/sha2_msg_schedule_sigma.sv | 34 +++
 rtl/sha2_msg_schedule.sv | 107 ++++++++++
 4 files changed

// File: rtl/sha2_msg_schedule_pkg.sv
// Shared types, sigma constants and rotate/shift helpers for the SHA-2 message schedule.
package sha2_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int ROUNDS_32 = 64;
    localparam int ROUNDS_64 = 80;

    localparam int S0_ROT_A_32 = 7;
    localparam int S0_ROT_B_32 = 18;
    localparam int S0_SHR_32   = 3;
    localparam int S1_ROT_A_32 = 17;
    localparam int S1_ROT_B_32 = 19;
    localparam int S1_SHR_32   = 10;

    localparam int S0_ROT_A_64 = 1;
    localparam int S0_ROT_B_64 = 8;
    localparam int S0_SHR_64   = 7;
    localparam int S1_ROT_A_64 = 19;
    localparam int S1_ROT_B_64 = 61;
    localparam int S1_SHR_64   = 6;

    // Operates on a 64-bit container; for w == 32 only the low half is meaningful.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [31:0] x32;
        logic [63:0] r;
        x32 = x[31:0];
        if (w == 32) begin
            r = {32'd0, (x32 >> n) | (x32 << (32 - n))};
        end else begin
            r = (x >> n) | (x << (64 - n));
        end
        return r;
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] x, input int n);
        return x >> n;
    endfunction

endpackage

// File: rtl/sha2_msg_schedule_if.sv
// Block-input and schedule-output streams of the SHA-2 message schedule.
// out_last exists only when SHA2_MSCHED_LAST_EN is defined.
interface sha2_msg_schedule_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [6:0]        out_idx;
`ifdef SHA2_MSCHED_LAST_EN
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
`endif
endinterface

// File: rtl/sha2_msg_schedule_sigma.sv
// SHA-2 small sigma pair: sig0 = sigma0(a), sig1 = sigma1(b), width-selected constants.
module sha2_small_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sig0,
    output logic [WORD_W-1:0] sig1
);
    localparam bit W64 = (WORD_W == 64);
    localparam int R0A = W64 ? S0_ROT_A_64 : S0_ROT_A_32;
    localparam int R0B = W64 ? S0_ROT_B_64 : S0_ROT_B_32;
    localparam int R0S = W64 ? S0_SHR_64   : S0_SHR_32;
    localparam int R1A = W64 ? S1_ROT_A_64 : S1_ROT_A_32;
    localparam int R1B = W64 ? S1_ROT_B_64 : S1_ROT_B_32;
    localparam int R1S = W64 ? S1_SHR_64   : S1_SHR_32;

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] sig0_ext;
    logic [63:0] sig1_ext;

    assign a_ext = 64'(a);
    assign b_ext = 64'(b);

    assign sig0_ext = rotr(a_ext, R0A, WORD_W) ^ rotr(a_ext, R0B, WORD_W) ^ shr(a_ext, R0S);
    assign sig1_ext = rotr(b_ext, R1A, WORD_W) ^ rotr(b_ext, R1B, WORD_W) ^ shr(b_ext, R1S);

    assign sig0 = sig0_ext[WORD_W-1:0];
    assign sig1 = sig1_ext[WORD_W-1:0];

endmodule

// File: rtl/sha2_msg_schedule.sv
// Buffered SHA-2 message schedule: loads 16 words, then streams W[0..ROUNDS-1].
// Optional out_last port enabled by SHA2_MSCHED_LAST_EN.
//
// state | meaning
// LOAD  | accepting M0..M15 into the shift buffer, cnt = words received
// EMIT  | presenting buf[0] as W[cnt], shifting in the next schedule word
module sha2_msg_schedule
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = ROUNDS_32
) (
    input  logic clk,
    input  logic rst,
    input  logic abort,
    sha2_msg_schedule_if.slave bus
);
    state_t            state;
    state_t            state_nxt;
    logic [6:0]        cnt;
    logic [6:0]        cnt_nxt;
    logic              shift_en;
    logic [WORD_W-1:0] shift_word;
    logic [WORD_W-1:0] sched_buf [16];
    logic [WORD_W-1:0] sig0;
    logic [WORD_W-1:0] sig1;
    logic [WORD_W-1:0] w_next;

    sha2_small_sigma #(.WORD_W(WORD_W)) u_sigma (
        .a    (sched_buf[1]),
        .b    (sched_buf[14]),
        .sig0 (sig0),
        .sig1 (sig1)
    );

    assign w_next = sig1 + sched_buf[9] + sig0 + sched_buf[0];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shift_en   = 1'b0;
        shift_word = bus.in_data;
        if (abort) begin
            state_nxt = LOAD;
            cnt_nxt   = 7'd0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        shift_en = 1'b1;
                        if (cnt == 7'd15) begin
                            state_nxt = EMIT;
                            cnt_nxt   = 7'd0;
                        end else begin
                            cnt_nxt = cnt + 7'd1;
                        end
                    end
                end
                EMIT: begin
                    shift_word = w_next;
                    if (bus.out_ready) begin
                        shift_en = 1'b1;
                        if (cnt == 7'(ROUNDS - 1)) begin
                            state_nxt = LOAD;
                            cnt_nxt   = 7'd0;
                        end else begin
                            cnt_nxt = cnt + 7'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = LOAD;
                    cnt_nxt   = 7'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= 7'd0;
            for (int i = 0; i < 16; i++) begin
                sched_buf[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (shift_en) begin
                for (int i = 0; i < 15; i++) begin
                    sched_buf[i] <= sched_buf[i+1];
                end
                sched_buf[15] <= shift_word;
            end
        end
    end

    // Handshake outputs are held low for the whole reset pulse, not just after the first edge.
    assign bus.in_ready  = (state == LOAD) & ~rst;
    assign bus.out_valid = (state == EMIT) & ~rst;
    assign bus.out_data  = sched_buf[0];
    assign bus.out_idx   = (state == EMIT) ? cnt : 7'd0;
`ifdef SHA2_MSCHED_LAST_EN
    assign bus.out_last  = bus.out_valid & (cnt == 7'(ROUNDS - 1));
`endif

endmodule
